pe_ctx_sequencer: RTL and testbench
===================================

# pe_ctx_sequencer

Context sequencer for one PE register-file slice in the CGRA. It holds a small context memory of control words and replays contexts 0..last_ctx for a programmed number of iterations. Each cycle it drives the register file's mux/demux selects, read/write addresses and write enables. It sits between the array-level configuration/start logic and the PE register file plus FU, and is the only source of those control lines.

## Interface
Parameters:
- DEPTH, 16: number of context words (power of two, 2..64).
- AW, 4: context address width, log2(DEPTH).
- ITW, 8: iteration counter width.

Ports:
- CLK  in  1  single clock. Outputs change on posedge; the register file samples on negedge.
- RST  in  1  synchronous, active-high reset.
- cfg_we  in  1  context-memory write strobe.
- cfg_addr  in  AW  context word address.
- cfg_wdata  in  58  context word: {control_in[57:49], control_out[48:40], control_reg_1[39:34], control_reg_2[33:28], control_put_in[27:22], control_put_out[21:16], control_send[15:10], control_pe2fu_1[9:6], control_pe2fu_2[5:2], write_back[1], ld_write[0]}.
- last_ctx  in  AW  index of the final context per iteration; sampled at start.
- iter_count  in  ITW  iterations to run; sampled at start; 0 is treated as 1.
- start  in  1  one-cycle start request.
- stall  in  1  freeze sequencing.
- abort  in  1  terminate the run.
- control_in, control_out  out  9 each  register-file input mux / output demux selects.
- control_reg_1, control_reg_2, control_put_in, control_put_out, control_send  out  6 each  register addresses.
- control_pe2fu_1, control_pe2fu_2  out  4 each  FU operand source selects.
- write_back, ld_write  out  1 each  write enables.
- ld  out  1  constant 1 (gates input writes with ld_write).
- busy  out  1  high in RUN.
- done  out  1  one-cycle completion pulse.
- ctx_ptr  out  AW  index of the context currently driven.

## Operation
- FSM states: IDLE, RUN.
  - IDLE -> RUN on start.
  - RUN -> IDLE after the last context of the last iteration is consumed, or on abort.
- Idle word: the value driven in IDLE, under RST, and in place of each stalled cycle's write enables.
  - control_in = 0 and control_out = 0.
  - All address fields = 0.
  - control_pe2fu_1 and control_pe2fu_2 = 4'b1111 (FU operand = 0).
  - write_back = 0, ld_write = 0.
- Reset values: all controls = idle word, busy = 0, done = 0, ctx_ptr = 0. Context memory is not cleared.
- cfg_we is honoured only in IDLE. Writes in RUN are dropped. Memory write is posedge.
- In RUN, each non-stalled cycle issues word[ctx_ptr], then:
  - if ctx_ptr < last_ctx: ctx_ptr++.
  - else: ctx_ptr = 0 and iterations-remaining decrements.
  - When iterations-remaining reaches 0 after issuing last_ctx, the FSM goes to IDLE.
- Stall in RUN: ctx_ptr, counters and all select/address outputs hold. write_back and ld_write are forced 0 so the held context never writes twice. When stall drops, the held context is reissued with its enables.
- start while busy is ignored. start and cfg_we in the same IDLE cycle: the write completes first, and the run sees the new word.
- abort has priority over stall and normal advance. Next cycle: IDLE, idle word, ctx_ptr = 0, no done pulse.
- abort together with start in IDLE: abort wins, and the run does not start.
- RST mid-run: same result as abort, plus done = 0.

## Timing
- Controls are registered. start at cycle t -> word 0 is driven at t+1, and busy = 1 from t+1.
- With no stalls, a run occupies (last_ctx+1)·max(iter_count,1) consecutive cycles.
- The cycle after the final word: idle word, busy = 0, done = 1 for exactly one cycle.
- A new start is accepted in the done cycle.
- last_ctx = 0: context 0 is repeated once per iteration.
- Writes land mid-cycle: the register file's negedge write sees the word driven at the preceding posedge.

## Structure
- Shared package pe_ctrl_pkg holds:
  - the field-offset constants of the 58-bit context word, with CTX_W = 58;
  - the IDLE_PE2FU = 4'b1111 constant;
  - the state enum {IDLE, RUN}.
- Optional sub-module pe_ctx_mem: DEPTH×58 register array, synchronous write, asynchronous read, no reset. Everything else stays in the top.

## Test plan
- Load 4 contexts (write_back = 1 in ctx 2, control_put_out = 6'd5). Apply last_ctx = 3, iter_count = 1, start at cycle 10 -> contexts 0..3 on cycles 11..14, write_back = 1 only on cycle 13, done on cycle 15.
- last_ctx = 2, iter_count = 3 -> ctx_ptr sequence 0,1,2,0,1,2,0,1,2 on 9 consecutive cycles, then a single done pulse.
- iter_count = 0, last_ctx = 1 -> behaves as one iteration: 2 cycles busy, then done.
- stall high for 3 cycles while ctx 1 (ld_write = 1) is driven -> ctx_ptr holds at 1, ld_write = 0 during the stall. ld_write = 1 on the first cycle after release. The run ends 3 cycles later than unstalled.
- abort on the 2nd context of a 5-context run -> next cycle idle word, busy = 0, done never asserted. A cfg_we during the run leaves memory unchanged (readback run shows the old word).
- RST asserted mid-run, then start -> run restarts from ctx 0 with iteration count re-sampled. All outputs showed reset values during RST.

Source files
------------

// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg
// Shared definitions for the PE context sequencer:
//   - bit offsets and widths of the 58-bit context word
//   - the idle word driven whenever no context is being issued
//   - the sequencer FSM state enum
// No ports (package).
package pe_ctrl_pkg;

   localparam int CTX_W = 58;

   // Context word layout, MSB to LSB.
   localparam int CIN_LSB    = 49;  // control_in      [57:49]
   localparam int COUT_LSB   = 40;  // control_out     [48:40]
   localparam int REG1_LSB   = 34;  // control_reg_1   [39:34]
   localparam int REG2_LSB   = 28;  // control_reg_2   [33:28]
   localparam int PUTIN_LSB  = 22;  // control_put_in  [27:22]
   localparam int PUTOUT_LSB = 16;  // control_put_out [21:16]
   localparam int SEND_LSB   = 10;  // control_send    [15:10]
   localparam int P2F1_LSB   = 6;   // control_pe2fu_1 [9:6]
   localparam int P2F2_LSB   = 2;   // control_pe2fu_2 [5:2]
   localparam int WB_BIT     = 1;   // write_back
   localparam int LDW_BIT    = 0;   // ld_write

   localparam int SEL_W  = 9;
   localparam int ADDR_W = 6;
   localparam int P2F_W  = 4;

   // FU operand select that feeds a constant 0 into the FU.
   localparam logic [P2F_W-1:0] IDLE_PE2FU = 4'b1111;

   // Everything zero except the FU operand selects.
   localparam logic [CTX_W-1:0] IDLE_WORD = {48'd0, IDLE_PE2FU, IDLE_PE2FU, 2'b00};

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/pe_ctx_mem.sv
// pe_ctx_mem
// DEPTH x CTX_W context memory: synchronous write, asynchronous read, no reset.
// Ports:
//   clk    in   clock (write on posedge)
//   we     in   write strobe
//   waddr  in   write address
//   wdata  in   write data (one context word)
//   raddr  in   read address
//   rdata  out  read data (combinational)
module pe_ctx_mem
   import pe_ctrl_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [CTX_W-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [CTX_W-1:0] rdata
);

   logic [CTX_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pe_ctx_sequencer.sv
// pe_ctx_sequencer
// Replays contexts 0..last_ctx for max(iter_count,1) iterations and drives the
// PE register-file / FU control lines from registered context words.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_wdata context memory write port (honoured in IDLE only)
//   last_ctx, iter_count     run shape, sampled with start
//   start, stall, abort      run control
//   control_* / write_back / ld_write   register-file and FU controls
//   ld                       constant 1
//   busy, done, ctx_ptr      status
//   dbg_state                current FSM state (debug)
//
// Control handshake: start is a single-cycle request, accepted only on a
// posedge where the FSM is IDLE and abort is low; there is no ready/ack, a
// start seen while busy is simply dropped. stall is level-sensitive and
// freezes the run for every cycle it is high; abort is a single-cycle request
// that wins over everything else except RST.
module pe_ctx_sequencer
   import pe_ctrl_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int ITW   = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [CTX_W-1:0] cfg_wdata,
   input  logic [AW-1:0]    last_ctx,
   input  logic [ITW-1:0]   iter_count,
   input  logic             start,
   input  logic             stall,
   input  logic             abort,
   output logic [8:0]       control_in,
   output logic [8:0]       control_out,
   output logic [5:0]       control_reg_1,
   output logic [5:0]       control_reg_2,
   output logic [5:0]       control_put_in,
   output logic [5:0]       control_put_out,
   output logic [5:0]       control_send,
   output logic [3:0]       control_pe2fu_1,
   output logic [3:0]       control_pe2fu_2,
   output logic             write_back,
   output logic             ld_write,
   output logic             ld,
   output logic             busy,
   output logic             done,
   output logic [AW-1:0]    ctx_ptr,
   output logic             dbg_state
);

   localparam logic [ITW-1:0] ITER_ONE = ITW'(1);

   state_t           state_q, state_n;
   logic [AW-1:0]    ptr_q, ptr_n;
   logic [AW-1:0]    last_q, last_n;
   logic [ITW-1:0]   iter_q, iter_n;
   logic [CTX_W-1:0] word_q, word_n;
   logic             done_q, done_n;

   logic             mem_we;
   logic [CTX_W-1:0] mem_rdata;
   logic             last_issue;
   logic             en_gate;

   // Configuration writes are dropped while a run is in progress.
   assign mem_we = cfg_we && (state_q == IDLE);

   pe_ctx_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (CLK),
      .we    (mem_we),
      .waddr (cfg_addr),
      .wdata (cfg_wdata),
      .raddr (ptr_n),
      .rdata (mem_rdata)
   );

   assign last_issue = (ptr_q == last_q) && (iter_q == ITER_ONE);

   // State and datapath registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         last_q  <= '0;
         iter_q  <= '0;
         word_q  <= IDLE_WORD;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         ptr_q   <= ptr_n;
         last_q  <= last_n;
         iter_q  <= iter_n;
         word_q  <= word_n;
         done_q  <= done_n;
      end
   end

   // Next-state logic.
   always_comb begin
      state_n = state_q;
      case (state_q)
         IDLE: if (start && !abort) state_n = RUN;
         RUN: begin
            if (abort) begin
               state_n = IDLE;
            end else if (!stall && last_issue) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Next values of the registered controls and counters.
   always_comb begin
      ptr_n  = ptr_q;
      last_n = last_q;
      iter_n = iter_q;
      done_n = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               ptr_n  = '0;
               last_n = last_ctx;
               iter_n = (iter_count == '0) ? ITER_ONE : iter_count;
            end
         end
         RUN: begin
            if (abort) begin
               ptr_n = '0;
            end else if (!stall) begin
               if (ptr_q < last_q) begin
                  ptr_n = ptr_q + 1'b1;
               end else begin
                  ptr_n  = '0;
                  iter_n = iter_q - ITER_ONE;
                  done_n = (iter_q == ITER_ONE);
               end
            end
         end
         default: ptr_n = '0;
      endcase

      // A write landing in the same edge as the fetch must be seen by the run.
      if (state_n == IDLE) begin
         word_n = IDLE_WORD;
      end else if (state_q == RUN && stall) begin
         word_n = word_q;
      end else if (mem_we && (cfg_addr == ptr_n)) begin
         word_n = cfg_wdata;
      end else begin
         word_n = mem_rdata;
      end
   end

   // Stall suppresses the enables in the same cycle so the register file's
   // negedge write never fires for a context that will be reissued.
   assign en_gate = !((state_q == RUN) && stall);

   assign control_in      = word_q[CIN_LSB    +: SEL_W];
   assign control_out     = word_q[COUT_LSB   +: SEL_W];
   assign control_reg_1   = word_q[REG1_LSB   +: ADDR_W];
   assign control_reg_2   = word_q[REG2_LSB   +: ADDR_W];
   assign control_put_in  = word_q[PUTIN_LSB  +: ADDR_W];
   assign control_put_out = word_q[PUTOUT_LSB +: ADDR_W];
   assign control_send    = word_q[SEND_LSB   +: ADDR_W];
   assign control_pe2fu_1 = word_q[P2F1_LSB   +: P2F_W];
   assign control_pe2fu_2 = word_q[P2F2_LSB   +: P2F_W];
   assign write_back      = word_q[WB_BIT]  & en_gate;
   assign ld_write        = word_q[LDW_BIT] & en_gate;
   assign ld              = 1'b1;
   assign busy            = (state_q == RUN);
   assign done            = done_q;
   assign ctx_ptr         = ptr_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_pe_ctx_sequencer.sv
// tb_pe_ctx_sequencer
// Directed bench for pe_ctx_sequencer: a reference memory image predicts every
// issued {ctx_ptr, control word}, queued when a run is launched and compared
// by a negedge monitor whenever busy is high.
module tb_pe_ctx_sequencer;

   localparam int W = 62;  // {ctx_ptr[3:0], word[57:0]}
   localparam logic [57:0] IDLE_W = 58'h3FC;
   localparam logic [57:0] EN_MASK = 58'h3;

   logic        CLK = 1'b0;
   logic        RST;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [57:0] cfg_wdata;
   logic [3:0]  last_ctx;
   logic [7:0]  iter_count;
   logic        start, stall, abort;
   logic [8:0]  control_in, control_out;
   logic [5:0]  control_reg_1, control_reg_2, control_put_in, control_put_out, control_send;
   logic [3:0]  control_pe2fu_1, control_pe2fu_2;
   logic        write_back, ld_write, ld, busy, done, dbg_state;
   logic [3:0]  ctx_ptr;

   logic [57:0] model_mem [16];
   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   logic [57:0] obs;
   assign obs = {control_in, control_out, control_reg_1, control_reg_2, control_put_in,
                 control_put_out, control_send, control_pe2fu_1, control_pe2fu_2,
                 write_back, ld_write};

   pe_ctx_sequencer #(.DEPTH(16), .AW(4), .ITW(8)) dut (
      .CLK (CLK), .RST (RST),
      .cfg_we (cfg_we), .cfg_addr (cfg_addr), .cfg_wdata (cfg_wdata),
      .last_ctx (last_ctx), .iter_count (iter_count),
      .start (start), .stall (stall), .abort (abort),
      .control_in (control_in), .control_out (control_out),
      .control_reg_1 (control_reg_1), .control_reg_2 (control_reg_2),
      .control_put_in (control_put_in), .control_put_out (control_put_out),
      .control_send (control_send),
      .control_pe2fu_1 (control_pe2fu_1), .control_pe2fu_2 (control_pe2fu_2),
      .write_back (write_back), .ld_write (ld_write), .ld (ld),
      .busy (busy), .done (done), .ctx_ptr (ctx_ptr), .dbg_state (dbg_state)
   );

   // Clock / reset block
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard monitor: every busy cycle consumes one expected issue.
   always @(negedge CLK) begin
      logic [W-1:0] e;
      if (busy === 1'b1) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : {W{1'bx}};
         check("issue", 64'({ctx_ptr, obs}), 64'(e));
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic cfg_write(input int addr, input logic [57:0] data);
      cfg_we = 1'b1;
      cfg_addr = addr[3:0];
      cfg_wdata = data;
      tick();
      cfg_we = 1'b0;
      model_mem[addr] = data;
   endtask

   function automatic logic [57:0] make_word(input logic wb, input logic ldw);
      logic [57:0] w;
      w = {$urandom(), $urandom()};
      w[21:16] = 6'd5;
      w[1] = wb;
      w[0] = ldw;
      return w;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_word"}, 64'(obs), 64'(IDLE_W));
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_ptr"}, 64'(ctx_ptr), 64'd0);
   endtask

   // Launches one run, queues the predicted issues, drives stall/start pokes
   // by cycle index and checks the done pulse and idle return.
   task automatic run_and_check(input string tag, input int last, input int iters,
                                input int stall_at, input int stall_len, input bit poke_start,
                                input bit wr_en, input int wr_addr, input logic [57:0] wr_data);
      int n_iter;
      int total;
      logic [3:0] cp;
      n_iter = (iters == 0) ? 1 : iters;
      if (wr_en) model_mem[wr_addr] = wr_data;
      for (int it = 0; it < n_iter; it++) begin
         for (int c = 0; c <= last; c++) begin
            cp = c[3:0];
            if (it == 0 && c == stall_at) begin
               repeat (stall_len) exp_q.push_back({cp, model_mem[c] & ~EN_MASK});
            end
            exp_q.push_back({cp, model_mem[c]});
         end
      end
      cfg_we = wr_en;
      cfg_addr = wr_addr[3:0];
      cfg_wdata = wr_data;
      last_ctx = last[3:0];
      iter_count = iters[7:0];
      start = 1'b1;
      tick();
      start = 1'b0;
      cfg_we = 1'b0;
      check({tag, "_busy_first"}, 64'(busy), 64'd1);
      total = (last + 1) * n_iter + stall_len;
      for (int k = 0; k < total; k++) begin
         stall = (stall_len > 0) && (k >= stall_at) && (k < stall_at + stall_len);
         start = poke_start && (k == 1);
         tick();
      end
      stall = 1'b0;
      start = 1'b0;
      check({tag, "_done"}, 64'(done), 64'd1);
      check_idle({tag, "_end"});
      check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
      tick();
      check({tag, "_done_once"}, 64'(done), 64'd0);
   endtask

   initial begin
      logic [57:0] w;
      RST = 1'b1;
      cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      last_ctx = '0; iter_count = '0;
      start = 1'b0; stall = 1'b0; abort = 1'b0;
      repeat (3) tick();
      check_idle("reset");
      check("reset_done", 64'(done), 64'd0);
      check("reset_ld", 64'(ld), 64'd1);
      RST = 1'b0;
      tick();

      // Context image: write_back only in ctx 2, ld_write only in ctx 1.
      for (int c = 0; c < 5; c++) begin
         w = make_word(c == 2, c == 1);
         cfg_write(c, w);
      end
      repeat (4) tick();

      run_and_check("basic", 3, 1, -1, 0, 1'b0, 1'b0, 0, '0);
      run_and_check("iter3", 2, 3, -1, 0, 1'b1, 1'b0, 0, '0);
      run_and_check("iter0", 1, 0, -1, 0, 1'b0, 1'b0, 0, '0);
      run_and_check("stall", 3, 2, 1, 3, 1'b0, 1'b0, 0, '0);
      w = make_word(1'b1, 1'b1);
      run_and_check("wr_start", 0, 3, -1, 0, 1'b0, 1'b1, 0, w);

      // abort together with start in IDLE: no run.
      last_ctx = 4'd2; iter_count = 8'd1;
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check_idle("abort_start");

      // Abort on the second context; a write during the run is dropped.
      exp_q.push_back({4'd0, model_mem[0]});
      exp_q.push_back({4'd1, model_mem[1]});
      last_ctx = 4'd4; iter_count = 8'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      cfg_we = 1'b1; cfg_addr = 4'd3; cfg_wdata = ~model_mem[3];
      tick();
      cfg_we = 1'b0;
      check("abort_ptr1", 64'(ctx_ptr), 64'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_idle("abort");
      check("abort_no_done", 64'(done), 64'd0);
      check("abort_drained", 64'(exp_q.size()), 64'd0);
      tick();
      check("abort_no_done2", 64'(done), 64'd0);
      run_and_check("readback", 3, 1, -1, 0, 1'b0, 1'b0, 0, '0);

      // Reset in the middle of a run, then restart with a new shape.
      exp_q.push_back({4'd0, model_mem[0]});
      exp_q.push_back({4'd1, model_mem[1]});
      exp_q.push_back({4'd2, model_mem[2]});
      exp_q.push_back({4'd0, model_mem[0]});
      last_ctx = 4'd2; iter_count = 8'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      RST = 1'b1;
      tick();
      check_idle("rst_mid");
      check("rst_mid_done", 64'(done), 64'd0);
      check("rst_mid_drained", 64'(exp_q.size()), 64'd0);
      tick();
      check_idle("rst_hold");
      RST = 1'b0;
      tick();
      run_and_check("after_rst", 1, 2, -1, 0, 1'b0, 1'b0, 0, '0);

      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
